pipeline_control: RTL

Consumer end of the hazard request/acknowledge handshake in the 5-stage pipeline. It takes the load-use and branch stall requests raised by the hazard unit, together with the cache handshake and the branch-resolution signals. From these it drives every pipeline-register enable and flush plus the PC enable. It returns the `flag_lu_done` / `flag_ju_done` acknowledges that release the hazard unit's held requests.

---
 rtl/pipeline_control_if.sv | 38 +++
 rtl/pipeline_control.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipeline_control_if.sv
// rtl/pipeline_control_if.sv - hazard/cache handshake and pipeline control bundle
interface pipeline_control_if;
    logic       ihit;
    logic       dmem_req;
    logic       dhit;
    logic       halt;
    logic       flag_lu;
    logic       load_use;
    logic       flag_ju;
    logic       jump_use;
    logic       branch_resolved;
    logic       jump_taken;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_flush;
    logic       exmem_en;
    logic       memwb_en;
    logic       flag_lu_done;
    logic       flag_ju_done;
    logic       halted;
    logic [1:0] ctrl_state;

    modport master (
        output ihit, dmem_req, dhit, halt, flag_lu, load_use, flag_ju, jump_use,
               branch_resolved, jump_taken,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
               flag_lu_done, flag_ju_done, halted, ctrl_state
    );

    modport slave (
        input  ihit, dmem_req, dhit, halt, flag_lu, load_use, flag_ju, jump_use,
               branch_resolved, jump_taken,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
               flag_lu_done, flag_ju_done, halted, ctrl_state
    );
endinterface

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - pipeline enable/flush sequencer answering hazard-unit stall requests
module pipeline_control #(
    parameter int LU_STALL_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               nRST,
    pipeline_control_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_WAIT  = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [2:0] CNT_INIT = (LU_STALL_CYCLES > 1) ? 3'(LU_STALL_CYCLES - 2) : 3'd0;

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       pend_ju, pend_n;
    logic       lu_done_q, lu_done_n;
    logic       ju_done_q, ju_done_n;
    logic       adv, pend_eff;
    logic       pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c, exmem_en_c, memwb_en_c;
    logic       jump_use_unused;

    assign jump_use_unused = bus.jump_use;
    assign adv      = bus.ihit & (~bus.dmem_req | bus.dhit);
    assign pend_eff = pend_ju | bus.flag_ju;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            cnt       <= 3'd0;
            pend_ju   <= 1'b0;
            lu_done_q <= 1'b0;
            ju_done_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            pend_ju   <= pend_n;
            lu_done_q <= lu_done_n;
            ju_done_q <= ju_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        pend_n       = pend_ju;
        lu_done_n    = 1'b0;
        ju_done_n    = 1'b0;
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        ifid_flush_c = 1'b0;
        idex_en_c    = 1'b0;
        idex_flush_c = 1'b0;
        exmem_en_c   = 1'b0;
        memwb_en_c   = 1'b0;
        if (bus.halt) begin
            state_n = HALTED;
        end else if (state != HALTED && adv) begin
            idex_en_c  = 1'b1;
            exmem_en_c = 1'b1;
            memwb_en_c = 1'b1;
            case (state)
                RUN: begin
                    if (bus.flag_lu) begin
                        idex_flush_c = 1'b1;
                        if (LU_STALL_CYCLES == 1) begin
                            lu_done_n = 1'b1;
                            if (bus.flag_ju) state_n = BR_WAIT;
                        end else begin
                            state_n = LU_STALL;
                            cnt_n   = CNT_INIT;
                            pend_n  = bus.flag_ju;
                        end
                    end else begin
                        pc_en_c      = 1'b1;
                        ifid_en_c    = 1'b1;
                        ifid_flush_c = bus.jump_taken;
                        if (bus.flag_ju) state_n = BR_WAIT;
                    end
                end
                LU_STALL: begin
                    idex_flush_c = 1'b1;
                    pend_n       = pend_eff;
                    // A dropped load_use level means the request was withdrawn: leave without acknowledging.
                    if (!bus.load_use || cnt == 3'd0) begin
                        state_n   = pend_eff ? BR_WAIT : RUN;
                        pend_n    = 1'b0;
                        lu_done_n = bus.load_use;
                    end else begin
                        cnt_n = cnt - 3'd1;
                    end
                end
                BR_WAIT: begin
                    ifid_en_c    = 1'b1;
                    ifid_flush_c = 1'b1;
                    if (bus.branch_resolved) begin
                        pc_en_c   = 1'b1;
                        state_n   = RUN;
                        ju_done_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_en        = nRST & pc_en_c;
    assign bus.ifid_en      = nRST & ifid_en_c;
    assign bus.ifid_flush   = nRST & ifid_flush_c;
    assign bus.idex_en      = nRST & idex_en_c;
    assign bus.idex_flush   = nRST & idex_flush_c;
    assign bus.exmem_en     = nRST & exmem_en_c;
    assign bus.memwb_en     = nRST & memwb_en_c;
    assign bus.flag_lu_done = lu_done_q;
    assign bus.flag_ju_done = ju_done_q;
    assign bus.halted       = (state == HALTED);
    assign bus.ctrl_state   = state;
endmodule
